responder_arbiter: RTL and testbench
====================================

# responder_arbiter

N-player quiz responder core: arms on Start, accepts the first eligible key press, locks the winner, runs the answer timer handshake, then shows a timed correct/wrong indication. Wrong answers can reopen the round to the remaining players. Players who press early are excluded as false starts. Sits between the key synchroniser/debouncer and the LED, buzzer and timer display logic.

## Interface
- N_PLAYERS, 4: player count, 2..16.
- WINDOW_CYCLES, 25_000_000: length of the correct/wrong indication, in clock cycles, ≥2.
- RR_MODE, 0: tie-break. 0 = lowest index wins. 1 = round-robin, starting from last winner + 1.
- REOPEN, 1: after a wrong answer, 1 = reopen to players not yet excluded, 0 = end round.
- PN_W (derived): clog2(N_PLAYERS+1). CNT_W (derived): clog2(WINDOW_CYCLES).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  high = idle/arm, low = round open.
- Key_n  in  N_PLAYERS  player keys, active-low, already synchronised and debounced.
- TimeOver_Block  in  1  high = ignore keys in OPEN.
- Judge_Valid  in  1  one-cycle pulse from host: verdict present.
- Judge_Correct  in  1  verdict; sampled only with Judge_Valid.
- LED_Out  out  N_PLAYERS  one-hot winner LED.
- Player_Number  out  PN_W  winner index+1; 0 = none.
- Timer_Start  out  1  high while winner holds the floor.
- Answer_true  out  1  correct indication, WINDOW_CYCLES long.
- Buzzer_Answer  out  1  wrong indication, WINDOW_CYCLES long.
- False_Start  out  N_PLAYERS  exclusion mask from early presses.
- Round_Void  out  1  high in DONE when the round ended with no correct answer.

All outputs reset to 0. The round-robin pointer resets to player 0.

## Operation
- States: IDLE, OPEN, LOCKED, SHOW_OK, SHOW_BAD, DONE.
- IDLE (Start=1):
  - Outputs cleared, except False_Start.
  - Any key low sets its False_Start bit.
  - Start falling goes to OPEN.
  - Excl mask = False_Start.
- OPEN:
  - Request vector req = ~Key_n & ~excl.
  - If TimeOver_Block=1, req is ignored and the state stays OPEN.
  - If req≠0: grant one player per RR_MODE, go to LOCKED. Latch LED_Out and Player_Number, set Timer_Start.
  - If RR_MODE=1, pointer = winner+1 mod N_PLAYERS.
  - If excl is all ones, go to DONE with Round_Void=1.
- LOCKED:
  - Keys are ignored.
  - Judge_Valid with Judge_Correct=1 goes to SHOW_OK. With Judge_Correct=0 goes to SHOW_BAD.
  - Timer_Start drops on leaving LOCKED.
- SHOW_OK: Answer_true=1 for exactly WINDOW_CYCLES cycles, then DONE.
- SHOW_BAD:
  - Buzzer_Answer=1 for exactly WINDOW_CYCLES cycles.
  - Winner's excl bit is set.
  - Then: if REOPEN=1 and any player is still eligible, go to OPEN with LED_Out and Player_Number cleared. Otherwise go to DONE with Round_Void=1.
- DONE:
  - Holds LED_Out and Player_Number.
  - Waits for Start=1.
- Start=1 in any non-IDLE state goes to IDLE on the next edge and clears everything except the pointer.
- On that exit from DONE/other state into IDLE, False_Start is cleared, then re-accumulates during IDLE.
- Judge_Valid outside LOCKED is ignored.

## Timing
- Key sampled low in OPEN at edge k: LED_Out, Player_Number and Timer_Start valid after edge k+1 (1-cycle latency).
- Judge_Valid at edge j: Answer_true or Buzzer_Answer rises after j+1 and falls after j+1+WINDOW_CYCLES.
- The window counter is CNT_W wide. It is cleared on entering SHOW_*, with terminal count WINDOW_CYCLES-1, and never wraps.
- Simultaneous presses in one cycle:
  - RR_MODE=0: lowest index wins.
  - RR_MODE=1: the first requester at or after the pointer, cyclic.
- Held keys after a reopen count as new requests immediately.
- RST mid-round: all state and outputs go to reset values at the next edge, and the pointer goes to 0.
- Start and RST both high: RST wins.

## Structure
- Package responder_pkg:
  - state enum resp_state_t.
  - RR_FIXED and RR_ROTATE constants.
  - function idx_to_onehot.
- Sub-module rr_arbiter (params N, ROTATE):
  - Inputs: req[N], ptr.
  - Combinational outputs: grant_onehot, grant_idx, any.
- Top-level: FSM, window counter, exclusion/false-start masks, output registers.

## Test plan
- Reset, Start 1→0, Key_n=4'b1011 → after 1 cycle: LED_Out=4'b0100, Player_Number=3, Timer_Start=1.
- RR_MODE=1, Key_n=4'b1100 in two consecutive rounds → winner P1 in round 1, then P2 in round 2.
- Key_n=4'b1110 while Start=1, then open round with P1 and P2 pressing → False_Start=4'b0001, winner P2.
- WINDOW_CYCLES=8, Judge_Valid with Judge_Correct=0, REOPEN=1 → Buzzer_Answer high exactly 8 cycles, then OPEN; P1 press ignored, P3 press wins.
- TimeOver_Block=1 with keys pressed → no winner. Drop the block → winner next cycle. With all four excluded → Round_Void=1.
- RST asserted during SHOW_OK, and Start=1 during LOCKED → all outputs 0 at the next edge.

Source files
------------

// File: rtl/responder_pkg.sv
// Shared types, constants and helpers for the quiz responder core.
package responder_pkg;

  localparam int MAX_PLAYERS = 16;
  localparam int RR_FIXED    = 0;
  localparam int RR_ROTATE   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN,
    ST_LOCKED,
    ST_SHOW_OK,
    ST_SHOW_BAD,
    ST_DONE
  } resp_state_t;

  function automatic logic [MAX_PLAYERS-1:0] idx_to_onehot(input logic [3:0] idx);
    logic [MAX_PLAYERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: fixed lowest-index priority, or cyclic priority starting at ptr.
module rr_arbiter
  import responder_pkg::*;
#(
  parameter int  N      = 4,
  parameter bit  ROTATE = 1'b0,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    int base;
    int j;
    grant_idx    = '0;
    any          = 1'b0;
    grant_onehot = '0;
    base         = ROTATE ? int'(ptr) : 0;
    j            = 0;
    for (int i = 0; i < N; i++) begin
      j = base + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        grant_idx = IDX_W'(j);
        any       = 1'b1;
      end
    end
    if (any) grant_onehot = N'(idx_to_onehot(4'(grant_idx)));
  end

endmodule

// File: rtl/responder_arbiter.sv
// Quiz responder core: arm, first-press lock, judge handshake, timed verdict, optional reopen.
module responder_arbiter
  import responder_pkg::*;
#(
  parameter int  N_PLAYERS     = 4,
  parameter int  WINDOW_CYCLES = 25_000_000,
  parameter int  RR_MODE       = RR_FIXED,
  parameter int  REOPEN        = 1,
  localparam int PN_W          = $clog2(N_PLAYERS + 1),
  localparam int CNT_W         = $clog2(WINDOW_CYCLES),
  localparam int IDX_W         = $clog2(N_PLAYERS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [N_PLAYERS-1:0] Key_n,
  input  logic                 TimeOver_Block,
  input  logic                 Judge_Valid,
  input  logic                 Judge_Correct,
  output logic [N_PLAYERS-1:0] LED_Out,
  output logic [PN_W-1:0]      Player_Number,
  output logic                 Timer_Start,
  output logic                 Answer_true,
  output logic                 Buzzer_Answer,
  output logic [N_PLAYERS-1:0] False_Start,
  output logic                 Round_Void
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PLAYERS - 1);

  resp_state_t          state_q, state_d;
  logic [N_PLAYERS-1:0] excl_q, excl_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_PLAYERS-1:0] led_d, fs_d;
  logic [PN_W-1:0]      pn_d;
  logic                 timer_d, ok_d, bad_d, void_d;

  logic [N_PLAYERS-1:0] req, grant_onehot;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;

  assign req = ~Key_n & ~excl_q;

  rr_arbiter #(
    .N      (N_PLAYERS),
    .ROTATE (RR_MODE == RR_ROTATE)
  ) u_arb (
    .req          (req),
    .ptr          (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  always_comb begin
    // NOTE: every *_d takes its hold value first, so no branch below can leave one unassigned and infer a latch.
    state_d = state_q;
    excl_d  = excl_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    led_d   = LED_Out;
    pn_d    = Player_Number;
    timer_d = Timer_Start;
    ok_d    = Answer_true;
    bad_d   = Buzzer_Answer;
    fs_d    = False_Start;
    void_d  = Round_Void;

    if (Start && state_q != ST_IDLE) begin
      // Abort back to idle; only the round-robin pointer survives.
      state_d = ST_IDLE;
      excl_d  = '0;
      cnt_d   = '0;
      led_d   = '0;
      pn_d    = '0;
      timer_d = 1'b0;
      ok_d    = 1'b0;
      bad_d   = 1'b0;
      fs_d    = '0;
      void_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          led_d   = '0;
          pn_d    = '0;
          timer_d = 1'b0;
          ok_d    = 1'b0;
          bad_d   = 1'b0;
          void_d  = 1'b0;
          if (Start) begin
            fs_d = False_Start | ~Key_n;
          end else begin
            state_d = ST_OPEN;
            excl_d  = False_Start;
          end
        end
        ST_OPEN: begin
          if (&excl_q) begin
            state_d = ST_DONE;
            void_d  = 1'b1;
          end else if (!TimeOver_Block && grant_any) begin
            state_d = ST_LOCKED;
            led_d   = grant_onehot;
            pn_d    = PN_W'(grant_idx) + PN_W'(1);
            timer_d = 1'b1;
            if (RR_MODE == RR_ROTATE)
              ptr_d = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
          end
        end
        ST_LOCKED: begin
          if (Judge_Valid) begin
            timer_d = 1'b0;
            cnt_d   = '0;
            if (Judge_Correct) begin
              state_d = ST_SHOW_OK;
              ok_d    = 1'b1;
            end else begin
              state_d = ST_SHOW_BAD;
              bad_d   = 1'b1;
              excl_d  = excl_q | LED_Out;
            end
          end
        end
        ST_SHOW_OK: begin
          if (cnt_q == CNT_TERM) begin
            state_d = ST_DONE;
            ok_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW_BAD: begin
          if (cnt_q == CNT_TERM) begin
            bad_d = 1'b0;
            if (REOPEN != 0 && !(&excl_q)) begin
              state_d = ST_OPEN;
              led_d   = '0;
              pn_d    = '0;
            end else begin
              state_d = ST_DONE;
              void_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (RST) begin
      state_q       <= ST_IDLE;
      excl_q        <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      LED_Out       <= '0;
      Player_Number <= '0;
      Timer_Start   <= 1'b0;
      Answer_true   <= 1'b0;
      Buzzer_Answer <= 1'b0;
      False_Start   <= '0;
      Round_Void    <= 1'b0;
    end else begin
      state_q       <= state_d;
      excl_q        <= excl_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      LED_Out       <= led_d;
      Player_Number <= pn_d;
      Timer_Start   <= timer_d;
      Answer_true   <= ok_d;
      Buzzer_Answer <= bad_d;
      False_Start   <= fs_d;
      Round_Void    <= void_d;
    end
  end

endmodule

// File: tb/tb_responder_arbiter.sv
// Bench: fixed-priority and round-robin instances driven in parallel, directed scenarios plus a randomized run against a round-level model.
module tb_responder_arbiter;

  localparam int NP = 4;
  localparam int W  = 8;
  localparam int RO = 1;

  logic       clk = 1'b0;
  logic       rst, start, blk, jv, jc;
  logic [3:0] key_n;

  logic [3:0] led    [2];
  logic [2:0] pn     [2];
  logic [3:0] fs     [2];
  logic       timer  [2];
  logic       ans    [2];
  logic       buz    [2];
  logic       void_o [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    responder_arbiter #(
      .N_PLAYERS     (NP),
      .WINDOW_CYCLES (W),
      .RR_MODE       (g),
      .REOPEN        (RO)
    ) u_dut (
      .CLK            (clk),
      .RST            (rst),
      .Start          (start),
      .Key_n          (key_n),
      .TimeOver_Block (blk),
      .Judge_Valid    (jv),
      .Judge_Correct  (jc),
      .LED_Out        (led[g]),
      .Player_Number  (pn[g]),
      .Timer_Start    (timer[g]),
      .Answer_true    (ans[g]),
      .Buzzer_Answer  (buz[g]),
      .False_Start    (fs[g]),
      .Round_Void     (void_o[g])
    );
  end

  // Round-level reference: what phase the round is in, who holds the floor, and who is out.
  typedef struct {
    bit         idle;
    bit         open;
    bit         locked;
    bit         ended;
    bit         ok;
    int         show_left;
    int         winner;
    logic [3:0] excl;
    logic [3:0] fs;
    bit         void_f;
    int         ptr;
  } mdl_t;

  mdl_t mdl [2];

  function automatic mdl_t mdl_clear(int keep_ptr);
    mdl_t m;
    m.idle = 1; m.open = 0; m.locked = 0; m.ended = 0; m.ok = 0;
    m.show_left = 0; m.winner = -1; m.excl = '0; m.fs = '0; m.void_f = 0;
    m.ptr = keep_ptr;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit rot, bit r, bit s, logic [3:0] k,
                                    bit b, bit v, bit c);
    mdl_t       n;
    logic [3:0] rq;
    int         w;
    int         cand;
    n = m;
    if (r) return mdl_clear(0);
    if (s && !m.idle) return mdl_clear(m.ptr);
    if (m.idle) begin
      if (s) n.fs = m.fs | ~k;
      else begin n.idle = 0; n.open = 1; n.excl = m.fs; end
    end else if (m.open) begin
      if (m.excl == 4'hF) begin
        n.open = 0; n.ended = 1; n.void_f = 1;
      end else if (!b) begin
        rq = ~k & ~m.excl;
        w  = -1;
        for (int i = 0; i < NP; i++) begin
          cand = rot ? (m.ptr + i) % NP : i;
          if (w < 0 && rq[cand]) w = cand;
        end
        if (w >= 0) begin
          n.open = 0; n.locked = 1; n.winner = w;
          if (rot) n.ptr = (w + 1) % NP;
        end
      end
    end else if (m.locked) begin
      if (v) begin
        n.locked = 0; n.show_left = W; n.ok = c;
        if (!c) n.excl[m.winner] = 1'b1;
      end
    end else if (m.show_left > 0) begin
      n.show_left = m.show_left - 1;
      if (n.show_left == 0) begin
        if (m.ok) n.ended = 1;
        else if (RO != 0 && m.excl != 4'hF) begin n.open = 1; n.winner = -1; end
        else begin n.ended = 1; n.void_f = 1; end
      end
    end
    return n;
  endfunction

  function automatic logic [14:0] exp_outs(mdl_t m);
    logic [3:0] l;
    logic [2:0] p;
    l = (m.winner >= 0) ? 4'(1 << m.winner) : 4'b0;
    p = 3'(m.winner + 1);
    return {l, p, m.locked, (m.show_left > 0) && m.ok, (m.show_left > 0) && !m.ok,
            m.fs, m.void_f};
  endfunction

  function automatic logic [14:0] obs(int d);
    return {led[d], pn[d], timer[d], ans[d], buz[d], fs[d], void_o[d]};
  endfunction

  initial begin
    mdl[0] = mdl_clear(0);
    mdl[1] = mdl_clear(0);
  end

  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      mdl[d] = mdl_step(mdl[d], d == 1, rst, start, key_n, blk, jv, jc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; start = 1; key_n = '1; blk = 0; jv = 0; jc = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic open_round();
    key_n = '1; start = 1;
    tick();
    start = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs(d) !== 15'h0) begin
        bad++; $display("FAIL reset dut%0d outs got=%h want=0", d, obs(d));
      end
    end
  endtask

  task automatic test_first_press();
    do_reset();
    open_round();
    key_n = 4'b1011;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({led[d], pn[d], timer[d]} !== {4'b0100, 3'd3, 1'b1}) begin
        bad++; $display("FAIL first_press dut%0d led/pn/timer got=%b/%0d/%b want=0100/3/1",
                        d, led[d], pn[d], timer[d]);
      end
    end
    key_n = '1;
  endtask

  task automatic test_round_robin();
    logic [2:0] want [2];
    do_reset();
    open_round();
    key_n = 4'b1100;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pn[d] !== 3'd1) begin
        bad++; $display("FAIL rr_round1 dut%0d pn got=%0d want=1", d, pn[d]);
      end
    end
    open_round();
    key_n = 4'b1100;
    tick();
    want[0] = 3'd1;
    want[1] = 3'd2;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pn[d] !== want[d]) begin
        bad++; $display("FAIL rr_round2 dut%0d pn got=%0d want=%0d", d, pn[d], want[d]);
      end
    end
    key_n = '1;
  endtask

  task automatic test_false_start();
    do_reset();
    key_n = 4'b1110;
    tick();
    key_n = '1;
    start = 0;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (fs[d] !== 4'b0001) begin
        bad++; $display("FAIL false_start dut%0d mask got=%b want=0001", d, fs[d]);
      end
    end
    key_n = 4'b1100;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({led[d], pn[d]} !== {4'b0010, 3'd2}) begin
        bad++; $display("FAIL false_start_win dut%0d led/pn got=%b/%0d want=0010/2",
                        d, led[d], pn[d]);
      end
    end
    key_n = '1;
  endtask

  task automatic test_wrong_reopen();
    int cnt [2];
    do_reset();
    open_round();
    key_n = 4'b1110;
    tick();
    key_n = '1; jv = 1; jc = 0;
    tick();
    jv = 0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({buz[d], timer[d]} !== 2'b10) begin
        bad++; $display("FAIL wrong_entry dut%0d buz/timer got=%b/%b want=1/0", d, buz[d], timer[d]);
      end
      cnt[d] = buz[d] ? 1 : 0;
    end
    for (int i = 0; i < 20 && (buz[0] || buz[1]); i++) begin
      tick();
      for (int d = 0; d < 2; d++) if (buz[d]) cnt[d]++;
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (cnt[d] != W) begin
        bad++; $display("FAIL buzzer_len dut%0d cycles got=%0d want=%0d", d, cnt[d], W);
      end
      total++;
      if ({led[d], pn[d]} !== 7'h0) begin
        bad++; $display("FAIL reopen_clear dut%0d led/pn got=%b/%0d want=0000/0", d, led[d], pn[d]);
      end
    end
    key_n = 4'b1110;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pn[d] !== 3'd0) begin
        bad++; $display("FAIL excluded_press dut%0d pn got=%0d want=0", d, pn[d]);
      end
    end
    key_n = 4'b1010;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({led[d], pn[d]} !== {4'b0100, 3'd3}) begin
        bad++; $display("FAIL reopen_win dut%0d led/pn got=%b/%0d want=0100/3", d, led[d], pn[d]);
      end
    end
    key_n = '1;
  endtask

  task automatic test_correct();
    int cnt [2];
    do_reset();
    open_round();
    key_n = 4'b1101;
    tick();
    key_n = '1; jv = 1; jc = 1;
    tick();
    jv = 0;
    for (int d = 0; d < 2; d++) cnt[d] = ans[d] ? 1 : 0;
    for (int i = 0; i < 20 && (ans[0] || ans[1]); i++) begin
      tick();
      for (int d = 0; d < 2; d++) if (ans[d]) cnt[d]++;
    end
    jv = 1; jc = 0;
    tick();
    jv = 0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (cnt[d] != W) begin
        bad++; $display("FAIL answer_len dut%0d cycles got=%0d want=%0d", d, cnt[d], W);
      end
      total++;
      if ({led[d], pn[d], buz[d], void_o[d]} !== {4'b0010, 3'd2, 1'b0, 1'b0}) begin
        bad++; $display("FAIL done_hold dut%0d led/pn/buz/void got=%b/%0d/%b/%b want=0010/2/0/0",
                        d, led[d], pn[d], buz[d], void_o[d]);
      end
    end
  endtask

  task automatic test_timeover_void();
    do_reset();
    open_round();
    blk = 1; key_n = 4'b1101;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({pn[d], timer[d]} !== 4'h0) begin
        bad++; $display("FAIL blocked dut%0d pn/timer got=%0d/%b want=0/0", d, pn[d], timer[d]);
      end
    end
    blk = 0;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({pn[d], timer[d]} !== {3'd2, 1'b1}) begin
        bad++; $display("FAIL unblocked dut%0d pn/timer got=%0d/%b want=2/1", d, pn[d], timer[d]);
      end
    end
    start = 1; key_n = 4'b0000;
    tick(); tick();
    key_n = '1; start = 0;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({void_o[d], fs[d], pn[d]} !== {1'b1, 4'hF, 3'd0}) begin
        bad++; $display("FAIL all_excluded dut%0d void/fs/pn got=%b/%b/%0d want=1/1111/0",
                        d, void_o[d], fs[d], pn[d]);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    open_round();
    key_n = 4'b1110;
    tick();
    key_n = '1; jv = 1; jc = 1;
    tick();
    jv = 0;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (ans[d] !== 1'b1) begin
        bad++; $display("FAIL show_ok_pre dut%0d ans got=%b want=1", d, ans[d]);
      end
    end
    rst = 1;
    tick();
    rst = 0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs(d) !== 15'h0) begin
        bad++; $display("FAIL rst_midround dut%0d outs got=%h want=0", d, obs(d));
      end
    end
    open_round();
    key_n = 4'b0111;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({pn[d], timer[d]} !== {3'd4, 1'b1}) begin
        bad++; $display("FAIL after_rst_win dut%0d pn/timer got=%0d/%b want=4/1", d, pn[d], timer[d]);
      end
    end
    key_n = '1; start = 1;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs(d) !== 15'h0) begin
        bad++; $display("FAIL start_abort dut%0d outs got=%h want=0", d, obs(d));
      end
    end
  endtask

  task automatic test_random();
    logic [14:0] want;
    logic [3:0]  press;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 49) == 0);
      press = 4'($urandom & $urandom);
      key_n = ($urandom_range(0, 2) == 0) ? 4'hF : ~press;
      blk   = ($urandom_range(0, 5) == 0);
      jv    = ($urandom_range(0, 4) == 0);
      jc    = 1'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        want = exp_outs(mdl[d]);
        total++;
        if (obs(d) !== want) begin
          bad++; $display("FAIL random dut%0d cyc%0d outs got=%h want=%h", d, cyc, obs(d), want);
        end
      end
    end
    rst = 0; start = 1; jv = 0; key_n = '1;
  endtask

  initial begin
    rst = 1; start = 1; key_n = '1; blk = 0; jv = 0; jc = 0;
    test_reset();
    test_first_press();
    test_round_robin();
    test_false_start();
    test_wrong_reopen();
    test_correct();
    test_timeover_void();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
